// File: rtl/issue_hazard_unit.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | issue_hazard_unit - dual-issue scoreboard with pair split FSM           |
// | Optional macro: IHU_FORWARD_EN (counter==1 not busy for source reads)   |
// | Rev 1.0 - initial release                                               |
// +-------------------------------------------------------------------------+

`ifndef AWIDTH
`define AWIDTH 5
`endif
`ifndef OPCODE_WIDTH
`define OPCODE_WIDTH 6
`endif
`ifndef JR
`define JR 8
`endif

module issue_hazard_unit #(
  parameter int AW  = `AWIDTH,
  parameter int LAT = 3
) (
  input  logic                     ihu_i_clk,
  input  logic                     ihu_i_rst_n,
  input  logic                     ihu_i_valid_1,
  input  logic                     ihu_i_valid_2,
  input  logic [`OPCODE_WIDTH-1:0] ihu_i_op_1,
  input  logic [`OPCODE_WIDTH-1:0] ihu_i_op_2,
  input  logic [AW-1:0]            ihu_i_rs_1,
  input  logic [AW-1:0]            ihu_i_rt_1,
  input  logic [AW-1:0]            ihu_i_rd_1,
  input  logic [AW-1:0]            ihu_i_rs_2,
  input  logic [AW-1:0]            ihu_i_rt_2,
  input  logic [AW-1:0]            ihu_i_rd_2,
  input  logic                     ihu_i_we_1,
  input  logic                     ihu_i_we_2,
  input  logic                     ihu_i_flush,
  output logic                     ihu_o_issue_1,
  output logic                     ihu_o_issue_2,
  output logic                     ihu_o_ready,
  output logic                     ihu_o_split,
  output logic [(2**AW)-1:0]       ihu_o_busy
);

  localparam int NREG = 2**AW;
  localparam int CW   = 3;
  localparam logic [0:0] ST_PAIR   = 1'b0;
  localparam logic [0:0] ST_SECOND = 1'b1;

  logic [0:0]              state_q, state_d;
  logic [NREG-1:0][CW-1:0] cnt_q, cnt_d;
  logic [NREG-1:0]         w_src_busy;
  logic [NREG-1:0]         w_wr_busy;
  logic                    w_haz_1, w_haz_2, w_conflict;
  logic                    w_load_1, w_load_2;
  logic                    w_unused_op_1;

  assign w_unused_op_1 = ^ihu_i_op_1;

  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_busy
      assign w_wr_busy[gi] = (cnt_q[gi] != '0);
`ifdef IHU_FORWARD_EN
      // Last cycle before writeback is covered by the bypass network.
      assign w_src_busy[gi] = (cnt_q[gi] > CW'(1));
`else
      assign w_src_busy[gi] = w_wr_busy[gi];
`endif
    end
  endgenerate

  assign ihu_o_busy = w_wr_busy;

  assign w_haz_1 = w_src_busy[ihu_i_rs_1] | w_src_busy[ihu_i_rt_1] |
                   (ihu_i_we_1 & w_wr_busy[ihu_i_rd_1]);
  assign w_haz_2 = w_src_busy[ihu_i_rs_2] | w_src_busy[ihu_i_rt_2] |
                   (ihu_i_we_2 & w_wr_busy[ihu_i_rd_2]);

  // Slot 2 may not read or overwrite what slot 1 writes, and JR always goes alone.
  assign w_conflict = (ihu_i_we_1 && (ihu_i_rd_1 != '0) &&
                       ((ihu_i_rd_1 == ihu_i_rs_2) || (ihu_i_rd_1 == ihu_i_rt_2) ||
                        (ihu_i_rd_1 == ihu_i_rd_2))) ||
                      (ihu_i_op_2 == `OPCODE_WIDTH'(`JR));

  always_ff @(posedge ihu_i_clk) begin
    if (!ihu_i_rst_n) begin
      state_q <= ST_PAIR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (ihu_i_flush) begin
      state_d = ST_PAIR;
    end else begin
      case (state_q)
        ST_PAIR:   if (ihu_o_issue_1 && ihu_i_valid_2 && !ihu_o_issue_2) state_d = ST_SECOND;
        ST_SECOND: if (ihu_o_issue_2) state_d = ST_PAIR;
        default:   state_d = ST_PAIR;
      endcase
    end
  end

  always_comb begin
    ihu_o_issue_1 = 1'b0;
    ihu_o_issue_2 = 1'b0;
    ihu_o_ready   = 1'b0;
    ihu_o_split   = (state_q == ST_SECOND);
    if (!ihu_i_flush) begin
      case (state_q)
        ST_PAIR: begin
          ihu_o_issue_1 = ihu_i_valid_1 & ~w_haz_1;
          ihu_o_issue_2 = ihu_o_issue_1 & ihu_i_valid_2 & ~w_haz_2 & ~w_conflict;
          ihu_o_ready   = ihu_o_issue_1 & (ihu_o_issue_2 | ~ihu_i_valid_2);
        end
        ST_SECOND: begin
          ihu_o_issue_2 = ~w_haz_2;
          ihu_o_ready   = ihu_o_issue_2;
        end
        default: ;
      endcase
    end
  end

  assign w_load_1 = ihu_o_issue_1 & ihu_i_we_1;
  assign w_load_2 = ihu_o_issue_2 & ihu_i_we_2;

  always_comb begin
    cnt_d = cnt_q;
    for (int i = 0; i < NREG; i++) begin
      if (cnt_q[i] != '0) cnt_d[i] = cnt_q[i] - CW'(1);
      if ((i != 0) && ((w_load_1 && (ihu_i_rd_1 == AW'(i))) ||
                       (w_load_2 && (ihu_i_rd_2 == AW'(i))))) begin
        cnt_d[i] = CW'(LAT);
      end
    end
    cnt_d[0] = '0;
  end

endmodule

`default_nettype wire

// File: tb/tb_issue_hazard_unit.sv
`default_nettype none
// Testbench for issue_hazard_unit: vector table, timing sequences and a
// randomized run against a timestamp-based scoreboard model.

`ifndef AWIDTH
`define AWIDTH 5
`endif
`ifndef OPCODE_WIDTH
`define OPCODE_WIDTH 6
`endif
`ifndef JR
`define JR 8
`endif

module tb_issue_hazard_unit;

  localparam int AW   = `AWIDTH;
  localparam int LAT  = 3;
  localparam int NREG = 2**AW;
  localparam int OW   = `OPCODE_WIDTH;
  localparam logic [OW-1:0] OP_JR  = OW'(`JR);
  localparam logic [OW-1:0] OP_ADD = OW'(32);
`ifdef IHU_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic            clk;
  logic            rst_n;
  logic            valid_1, valid_2;
  logic [OW-1:0]   op_1, op_2;
  logic [AW-1:0]   rs_1, rt_1, rd_1, rs_2, rt_2, rd_2;
  logic            we_1, we_2;
  logic            flush;
  logic            issue_1, issue_2, ready, split;
  logic [NREG-1:0] busy;

  int n_checks = 0;
  int n_fail   = 0;

  issue_hazard_unit #(.AW(AW), .LAT(LAT)) dut (
    .ihu_i_clk     (clk),
    .ihu_i_rst_n   (rst_n),
    .ihu_i_valid_1 (valid_1),
    .ihu_i_valid_2 (valid_2),
    .ihu_i_op_1    (op_1),
    .ihu_i_op_2    (op_2),
    .ihu_i_rs_1    (rs_1),
    .ihu_i_rt_1    (rt_1),
    .ihu_i_rd_1    (rd_1),
    .ihu_i_rs_2    (rs_2),
    .ihu_i_rt_2    (rt_2),
    .ihu_i_rd_2    (rd_2),
    .ihu_i_we_1    (we_1),
    .ihu_i_we_2    (we_2),
    .ihu_i_flush   (flush),
    .ihu_o_issue_1 (issue_1),
    .ihu_o_issue_2 (issue_2),
    .ihu_o_ready   (ready),
    .ihu_o_split   (split),
    .ihu_o_busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    valid_1 = 0; valid_2 = 0; op_1 = OP_ADD; op_2 = OP_ADD;
    rs_1 = '0; rt_1 = '0; rd_1 = '0; rs_2 = '0; rt_2 = '0; rd_2 = '0;
    we_1 = 0; we_2 = 0; flush = 0;
  endtask

  task automatic set_group(input logic v1, input int a_rs1, input int a_rt1, input int a_rd1,
                           input logic w1, input logic v2, input logic [OW-1:0] o2,
                           input int a_rs2, input int a_rt2, input int a_rd2, input logic w2);
    valid_1 = v1; op_1 = OP_ADD;
    rs_1 = AW'(a_rs1); rt_1 = AW'(a_rt1); rd_1 = AW'(a_rd1); we_1 = w1;
    valid_2 = v2; op_2 = o2;
    rs_2 = AW'(a_rs2); rt_2 = AW'(a_rt2); rd_2 = AW'(a_rd2); we_2 = w2;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic v1; int rs1; int rt1; int rd1; logic we1;
    logic v2; logic [OW-1:0] op2; int rs2; int rt2; int rd2; logic we2;
    logic fl; logic e_i1; logic e_i2; logic e_rdy;
  } vec_t;

  vec_t vecs[11];

  // Scoreboard model: cycle index at which each register becomes free again.
  int free_at[NREG];
  bit m_split;
  int cyc;

  function automatic bit m_src_busy(input int r);
    if (FWD) return (cyc < free_at[r] - 1);
    return (cyc < free_at[r]);
  endfunction

  function automatic bit m_wr_busy(input int r);
    return (cyc < free_at[r]);
  endfunction

  initial begin
    int exp_c;
    bit need_new;
    bit h1, h2, conf, e1, e2, er;
    logic [NREG-1:0] e_busy;

    rst_n = 1'b0;
    clear_inputs();
    tick();
    do_reset();

    // Reset state
    sample();
    check("reset_busy",    64'(busy),    64'd0);
    check("reset_split",   64'(split),   64'd0);
    check("reset_issue_1", 64'(issue_1), 64'd0);
    check("reset_issue_2", 64'(issue_2), 64'd0);
    check("reset_ready",   64'(ready),   64'd0);

    // Single-cycle decisions from an idle scoreboard
    vecs[0]  = '{1,1,2,3,1, 1,OP_ADD,5,6,4,1, 0, 1,1,1};
    vecs[1]  = '{1,1,2,3,1, 1,OP_ADD,3,6,4,1, 0, 1,0,0};
    vecs[2]  = '{1,1,2,3,1, 1,OP_ADD,5,3,4,1, 0, 1,0,0};
    vecs[3]  = '{1,1,2,3,1, 1,OP_ADD,5,6,3,0, 0, 1,0,0};
    vecs[4]  = '{1,1,2,3,0, 1,OP_ADD,3,6,4,1, 0, 1,1,1};
    vecs[5]  = '{1,1,2,0,1, 1,OP_ADD,0,0,4,1, 0, 1,1,1};
    vecs[6]  = '{1,1,2,3,1, 1,OP_JR, 5,6,0,0, 0, 1,0,0};
    vecs[7]  = '{0,1,2,3,1, 1,OP_ADD,5,6,4,1, 0, 0,0,0};
    vecs[8]  = '{1,1,2,3,1, 0,OP_ADD,5,6,4,1, 0, 1,0,1};
    vecs[9]  = '{1,1,2,3,1, 1,OP_ADD,5,6,4,1, 1, 0,0,0};
    vecs[10] = '{1,1,2,3,1, 1,OP_ADD,5,6,1,1, 0, 1,1,1};
    for (int i = 0; i < 11; i++) begin
      do_reset();
      set_group(vecs[i].v1, vecs[i].rs1, vecs[i].rt1, vecs[i].rd1, vecs[i].we1,
                vecs[i].v2, vecs[i].op2, vecs[i].rs2, vecs[i].rt2, vecs[i].rd2, vecs[i].we2);
      flush = vecs[i].fl;
      sample();
      check($sformatf("vec%0d_issue_1", i), 64'(issue_1), 64'(vecs[i].e_i1));
      check($sformatf("vec%0d_issue_2", i), 64'(issue_2), 64'(vecs[i].e_i2));
      check($sformatf("vec%0d_ready", i),   64'(ready),   64'(vecs[i].e_rdy));
    end

    // Independent pair: both issue, both destinations busy c1..c3
    do_reset();
    set_group(1,1,2,3,1, 1,OP_ADD,5,6,4,1);
    sample();
    check("indep_c0_issue_2", 64'(issue_2), 64'd1);
    check("indep_c0_ready",   64'(ready),   64'd1);
    tick(); clear_inputs();
    for (int c = 1; c <= 4; c++) begin
      sample();
      check($sformatf("indep_c%0d_busy3", c), 64'(busy[3]), 64'(c <= 3));
      check($sformatf("indep_c%0d_busy4", c), 64'(busy[4]), 64'(c <= 3));
      tick();
    end

    // RAW inside pair: split, slot 2 waits for writeback
    do_reset();
    set_group(1,1,2,3,1, 1,OP_ADD,3,0,8,1);
    sample();
    check("raw_c0_issue_1", 64'(issue_1), 64'd1);
    check("raw_c0_issue_2", 64'(issue_2), 64'd0);
    exp_c = FWD ? LAT : LAT + 1;
    for (int c = 1; c <= exp_c; c++) begin
      tick(); sample();
      check($sformatf("raw_c%0d_split", c),   64'(split),   64'd1);
      check($sformatf("raw_c%0d_issue_1", c), 64'(issue_1), 64'd0);
      check($sformatf("raw_c%0d_issue_2", c), 64'(issue_2), 64'(c == exp_c));
      check($sformatf("raw_c%0d_ready", c),   64'(ready),   64'(c == exp_c));
    end
    tick(); clear_inputs(); sample();
    check("raw_after_split", 64'(split), 64'd0);

    // JR in slot 2 goes alone, one cycle later
    do_reset();
    set_group(1,1,2,3,1, 1,OP_JR,5,6,0,0);
    sample();
    check("jr_c0_issue_1", 64'(issue_1), 64'd1);
    check("jr_c0_issue_2", 64'(issue_2), 64'd0);
    tick(); sample();
    check("jr_c1_issue_2", 64'(issue_2), 64'd1);
    check("jr_c1_ready",   64'(ready),   64'd1);
    check("jr_c1_split",   64'(split),   64'd1);
    tick(); clear_inputs(); sample();
    check("jr_c2_split",   64'(split),   64'd0);

    // WAW on $7: never forwarded
    do_reset();
    set_group(1,1,2,7,1, 1,OP_ADD,5,6,7,1);
    sample();
    check("waw_c0_issue_2", 64'(issue_2), 64'd0);
    for (int c = 1; c <= 4; c++) begin
      tick(); sample();
      check($sformatf("waw_c%0d_issue_2", c), 64'(issue_2), 64'(c == 4));
    end
    tick(); clear_inputs();

    // Flush while in SECOND
    do_reset();
    set_group(1,1,2,3,1, 1,OP_ADD,3,0,8,1);
    sample();
    tick(); flush = 1'b1; sample();
    check("flush_c1_issue_2", 64'(issue_2), 64'd0);
    check("flush_c1_ready",   64'(ready),   64'd0);
    tick(); clear_inputs(); sample();
    check("flush_c2_split", 64'(split),   64'd0);
    check("flush_c2_busy3", 64'(busy[3]), 64'd1);
    tick(); tick(); sample();
    check("flush_c4_busy3", 64'(busy[3]), 64'd0);

    // Reset mid-flight clears scoreboard and split state
    do_reset();
    set_group(1,1,2,9,1, 1,OP_ADD,9,0,10,1);
    sample();
    check("rst_c0_issue_1", 64'(issue_1), 64'd1);
    tick(); rst_n = 1'b0; sample();
    check("rst_c1_busy9", 64'(busy[9]), 64'd1);
    check("rst_c1_split", 64'(split),   64'd1);
    tick(); rst_n = 1'b1; clear_inputs(); sample();
    check("rst_c2_busy",  64'(busy),  64'd0);
    check("rst_c2_split", 64'(split), 64'd0);

    // Writes to $0 never mark it busy
    set_group(1,1,2,0,1, 1,OP_ADD,5,6,0,1);
    sample();
    check("r0_issue_2", 64'(issue_2), 64'd1);
    tick(); clear_inputs(); sample();
    check("r0_busy", 64'(busy), 64'd0);

    // Randomized run against the scoreboard model
    do_reset();
    for (int r = 0; r < NREG; r++) free_at[r] = 0;
    m_split  = 1'b0;
    cyc      = 0;
    need_new = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      if (k != 0) tick();
      rst_n = ($urandom_range(0, 99) != 0);
      flush = ($urandom_range(0, 15) == 0);
      if (need_new) begin
        valid_1 = ($urandom_range(0, 7) != 0);
        valid_2 = ($urandom_range(0, 3) != 0);
        op_1 = OW'($urandom);
        op_2 = ($urandom_range(0, 7) == 0) ? OP_JR : OP_ADD;
        rs_1 = AW'($urandom_range(0, 7)); rt_1 = AW'($urandom_range(0, 7));
        rd_1 = AW'($urandom_range(0, 7)); we_1 = ($urandom_range(0, 3) != 0);
        rs_2 = AW'($urandom_range(0, 7)); rt_2 = AW'($urandom_range(0, 7));
        rd_2 = AW'($urandom_range(0, 7)); we_2 = ($urandom_range(0, 3) != 0);
      end
      sample();

      h1 = m_src_busy(int'(rs_1)) || m_src_busy(int'(rt_1)) || (we_1 && m_wr_busy(int'(rd_1)));
      h2 = m_src_busy(int'(rs_2)) || m_src_busy(int'(rt_2)) || (we_2 && m_wr_busy(int'(rd_2)));
      conf = (we_1 && rd_1 != '0 && (rd_1 == rs_2 || rd_1 == rt_2 || rd_1 == rd_2)) || (op_2 == OP_JR);
      e1 = 0; e2 = 0; er = 0;
      if (!flush) begin
        if (m_split) begin
          e2 = !h2; er = e2;
        end else begin
          e1 = valid_1 && !h1;
          e2 = e1 && valid_2 && !h2 && !conf;
          er = e1 && (e2 || !valid_2);
        end
      end
      for (int r = 0; r < NREG; r++) e_busy[r] = m_wr_busy(r);

      if (rst_n) begin
        check($sformatf("rand%0d_issue_1", k), 64'(issue_1), 64'(e1));
        check($sformatf("rand%0d_issue_2", k), 64'(issue_2), 64'(e2));
        check($sformatf("rand%0d_ready", k),   64'(ready),   64'(er));
      end
      check($sformatf("rand%0d_split", k), 64'(split), 64'(m_split));
      check($sformatf("rand%0d_busy", k),  64'(busy),  64'(e_busy));

      if (!rst_n) begin
        for (int r = 0; r < NREG; r++) free_at[r] = 0;
        m_split = 1'b0;
      end else begin
        if (e1 && we_1 && rd_1 != '0) free_at[int'(rd_1)] = cyc + LAT + 1;
        if (e2 && we_2 && rd_2 != '0) free_at[int'(rd_2)] = cyc + LAT + 1;
        if (flush)        m_split = 1'b0;
        else if (m_split) m_split = !e2;
        else              m_split = e1 && valid_2 && !e2;
      end
      need_new = !rst_n || flush || er || !valid_1;
      cyc++;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
